// File: rtl/vga_fb_arbiter_if.sv
// Bundles the timing-generator, CPU and video-BRAM signals around the frame-buffer arbiter.
// slave = arbiter side; master = timing generator, CPU and BRAM side.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              newline;
  logic              ve;
  logic [9:0]        x;
  logic [9:0]        y;
  logic              pixel;
  logic              underrun;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  newline, ve, x, y, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output pixel, underrun, cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output newline, ve, x, y, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  pixel, underrun, cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port video BRAM: per-line prefetch into a line buffer (LINE_WORDS+1 cycles), CPU otherwise.
// Pixel out 1 cycle after x; CPU access 2 cycles when idle, held off by at most one line fetch (LINE_WORDS+4).
module vga_fb_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 20,
  parameter int V_ACTIVE   = 480,
  parameter int FB_BASE    = 0
) (
  input  logic                clk_p,
  input  logic                rst,
  vga_fb_arbiter_if.slave     bus
);
  localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, CPU_ISSUE, CPU_ACK} state_t;

  state_t            state_q, state_d;
  logic              fetch_pending_q, fetch_pending_d;
  logic [9:0]        fetch_line_q, fetch_line_d;
  logic [IW-1:0]     i_q, i_d;
  logic              cap_vld_q, cap_vld_d;
  logic [IW-1:0]     cap_idx_q, cap_idx_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              acc_we_q, acc_we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pixel_q, pixel_d;
  logic              underrun_q, underrun_d;

  logic [DATA_W-1:0] linebuf [LINE_WORDS];
  logic [DATA_W-1:0] rd_word;
  logic              trigger;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [9:0] line);
    return ADDR_W'(FB_BASE) + ADDR_W'(line) * ADDR_W'(LINE_WORDS);
  endfunction

  always_comb begin
    state_d         = state_q;
    i_d             = i_q;
    cap_vld_d       = 1'b0;
    cap_idx_d       = cap_idx_q;
    mem_en_d        = 1'b0;
    mem_we_d        = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    cpu_ack_d       = 1'b0;
    acc_we_d        = acc_we_q;
    rdata_d         = rdata_q;

    trigger         = bus.newline && (bus.y < 10'(V_ACTIVE));
    fetch_line_d    = trigger ? bus.y : fetch_line_q;
    // A trigger in an idle cycle is granted immediately so the first read lands one cycle after newline.
    fetch_pending_d = fetch_pending_q | trigger;

    case (state_q)
      IDLE: begin
        if (fetch_pending_d) begin
          state_d         = FETCH;
          fetch_pending_d = 1'b0;
          i_d             = '0;
          mem_en_d        = 1'b1;
          mem_addr_d      = line_addr(fetch_line_d);
        end else if (bus.cpu_req) begin
          state_d     = CPU_ISSUE;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.cpu_we;
          mem_addr_d  = bus.cpu_addr;
          mem_wdata_d = bus.cpu_wdata;
          acc_we_d    = bus.cpu_we;
        end
      end
      FETCH: begin
        cap_vld_d = 1'b1;
        cap_idx_d = i_q;
        if (i_q == IW'(LINE_WORDS - 1)) begin
          state_d = DRAIN;
        end else begin
          i_d        = i_q + 1'b1;
          mem_en_d   = 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
        end
      end
      DRAIN: state_d = IDLE;
      CPU_ISSUE: begin
        state_d   = CPU_ACK;
        cpu_ack_d = 1'b1;
      end
      CPU_ACK: begin
        state_d = IDLE;
        if (!acc_we_q) rdata_d = bus.mem_rdata;
      end
      default: state_d = IDLE;
    endcase

    underrun_d = underrun_q |
                 (bus.ve & ((state_q == FETCH) || (state_q == DRAIN) || fetch_pending_q));

    rd_word = '0;
    if (bus.x[9:5] < 5'(LINE_WORDS)) rd_word = linebuf[IW'(bus.x[9:5])];
    // Bit 31 of each word is the leftmost pixel of its 32-pixel span.
    pixel_d = bus.ve & rd_word[~bus.x[4:0]];
  end

  always_ff @(posedge clk_p or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      fetch_pending_q <= 1'b0;
      fetch_line_q    <= '0;
      i_q             <= '0;
      cap_vld_q       <= 1'b0;
      cap_idx_q       <= '0;
      mem_en_q        <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      cpu_ack_q       <= 1'b0;
      acc_we_q        <= 1'b0;
      rdata_q         <= '0;
      pixel_q         <= 1'b0;
      underrun_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pending_q <= fetch_pending_d;
      fetch_line_q    <= fetch_line_d;
      i_q             <= i_d;
      cap_vld_q       <= cap_vld_d;
      cap_idx_q       <= cap_idx_d;
      mem_en_q        <= mem_en_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      cpu_ack_q       <= cpu_ack_d;
      acc_we_q        <= acc_we_d;
      rdata_q         <= rdata_d;
      pixel_q         <= pixel_d;
      underrun_q      <= underrun_d;
    end
  end

  always_ff @(posedge clk_p) begin
    if (cap_vld_q) linebuf[cap_idx_q] <= bus.mem_rdata;
  end

  assign bus.pixel     = pixel_q;
  assign bus.underrun  = underrun_q;
  assign bus.cpu_ack   = cpu_ack_q;
  // Read data is taken straight from the BRAM in the ack cycle and held afterwards.
  assign bus.cpu_rdata = (cpu_ack_q && !acc_we_q) ? bus.mem_rdata : rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a BRAM model and queue-based scoreboards.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_vga_fb_arbiter;
  logic clk_p = 1'b0;
  logic rst   = 1'b0;

  vga_fb_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus();

  vga_fb_arbiter dut (
    .clk_p (clk_p),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk_p = ~clk_p;

  logic [31:0] mem [16384];

  always @(posedge clk_p) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  int          total    = 0;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          cyc      = 0;
  int          ack_cnt  = 0;
  logic [13:0] addr_q [$];
  logic        pix_q  [$];
  logic [31:0] rd_q   [$];
  logic [31:0] exp_line [20];
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_p);
    cyc++;
    if (bus.mem_en) begin
      if (addr_q.size() == 0) chk("mem_en_unexpected", 32'(bus.mem_en), 32'h0);
      else chk("mem_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
    end
    if (pix_q.size() != 0) chk("pixel", 32'(bus.pixel), 32'(pix_q.pop_front()));
    if (bus.cpu_ack) begin
      ack_cnt++;
      if (rd_q.size() == 0) chk("cpu_ack_unexpected", 32'(bus.cpu_ack), 32'h0);
      else chk("cpu_rdata", bus.cpu_rdata, rd_q.pop_front());
    end
    bus.newline = 1'b0;
  endtask

  function automatic logic exp_pix(input logic v, input logic [9:0] xx);
    if (!v || xx[9:5] >= 5'd20) return 1'b0;
    return exp_line[xx[9:5]][31 - int'(xx[4:0])];
  endfunction

  task automatic video_cycle(input logic v, input logic [9:0] xx);
    bus.ve = v;
    bus.x  = xx;
    pix_q.push_back(exp_pix(v, xx));
    tick();
  endtask

  task automatic start_fetch(input logic [9:0] yy);
    bus.newline = 1'b1;
    bus.y       = yy;
    if (yy < 10'd480) begin
      for (int w = 0; w < 20; w++) begin
        addr_q.push_back(14'(int'(yy) * 20 + w));
        exp_line[w] = mem[int'(yy) * 20 + w];
      end
    end
  endtask

  task automatic run_line(input logic [9:0] yy, input int bp, input int nvis);
    start_fetch(yy);
    repeat (bp) video_cycle(1'b0, 10'd0);
    for (int i = 0; i < nvis; i++) video_cycle(1'b1, 10'(i));
    repeat (2) video_cycle(1'b0, 10'd0);
  endtask

  task automatic cpu_access(input logic we, input logic [13:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input int exp_lat);
    int  t0;
    int  lat;
    bit  got;
    t0  = cyc;
    lat = -1;
    got = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    addr_q.push_back(a);
    rd_q.push_back(we ? last_rd : exp_rd);
    if (!we) last_rd = exp_rd;
    for (int k = 0; k < 100 && !got; k++) begin
      tick();
      if (bus.cpu_ack) begin
        got = 1'b1;
        lat = cyc - t0;
      end
    end
    bus.cpu_req = 1'b0;
    chk("cpu_latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int acks_before;
    bus.newline = 1'b0; bus.ve = 1'b0; bus.x = '0; bus.y = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'hAAAA_AAAA;
    for (int i = 60; i < 80; i++) mem[i] = 32'(i);
    mem[14'h100] = 32'hDEAD_BEEF;

    // Reset state
    repeat (2) tick();
    chk("rst_mem_en",    32'(bus.mem_en),    32'h0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'h0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
    chk("rst_mem_wdata", bus.mem_wdata,      32'h0);
    chk("rst_pixel",     32'(bus.pixel),     32'h0);
    chk("rst_underrun",  32'(bus.underrun),  32'h0);
    chk("rst_cpu_ack",   32'(bus.cpu_ack),   32'h0);
    chk("rst_cpu_rdata", bus.cpu_rdata,      32'h0);
    rst = 1'b1;
    repeat (3) tick();

    // Checkerboard lines, vertical blank, more lines
    run_line(10'd0, 30, 640);
    run_line(10'd1, 30, 640);
    run_line(10'd500, 30, 0);
    run_line(10'd0, 30, 640);
    chk("underrun_normal", 32'(bus.underrun), 32'h0);
    chk("fetch_queue_drained", 32'(addr_q.size()), 32'h0);

    // Line 3 prefetch and boundary pixels
    start_fetch(10'd3);
    video_cycle(1'b0, 10'd0);
    chk("fetch_start_en", 32'(bus.mem_en), 32'h1);
    repeat (24) video_cycle(1'b0, 10'd0);
    chk("line3_fetched", 32'(addr_q.size()), 32'h0);
    video_cycle(1'b1, 10'd160);
    video_cycle(1'b1, 10'd185);
    video_cycle(1'b1, 10'd191);
    video_cycle(1'b1, 10'd639);
    video_cycle(1'b1, 10'd700);
    video_cycle(1'b1, 10'd1023);
    video_cycle(1'b0, 10'd191);
    video_cycle(1'b0, 10'd0);

    // Idle CPU read
    cpu_access(1'b0, 14'h100, 32'h0, 32'hDEAD_BEEF, 2);
    tick();

    // CPU write colliding with a newline: fetch goes first
    start_fetch(10'd0);
    cpu_access(1'b1, 14'h200, 32'h1234_5678, 32'h0, 24);
    tick();
    cpu_access(1'b0, 14'h200, 32'h0, 32'h1234_5678, 2);
    tick();

    // ve asserted during the fetch
    start_fetch(10'd1);
    repeat (5) video_cycle(1'b0, 10'd0);
    video_cycle(1'b1, 10'd0);
    video_cycle(1'b0, 10'd0);
    chk("underrun_set", 32'(bus.underrun), 32'h1);
    repeat (20) video_cycle(1'b0, 10'd0);
    chk("underrun_sticky", 32'(bus.underrun), 32'h1);

    // Asynchronous reset in the middle of a fetch with a CPU request pending
    start_fetch(10'd2);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 14'h100;
    repeat (5) video_cycle(1'b0, 10'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst_mem_en",   32'(bus.mem_en),   32'h0);
    chk("arst_underrun", 32'(bus.underrun), 32'h0);
    chk("arst_cpu_ack",  32'(bus.cpu_ack),  32'h0);
    addr_q.delete();
    pix_q.delete();
    last_rd     = 32'h0;
    bus.cpu_req = 1'b0;
    acks_before = ack_cnt;
    repeat (2) tick();
    rst = 1'b1;
    repeat (30) tick();
    chk("no_ack_after_abort", 32'(ack_cnt - acks_before), 32'h0);

    // Vertical blank newlines do not fetch; CPU gets 2-cycle service
    start_fetch(10'd500);
    cpu_access(1'b0, 14'h100, 32'h0, 32'hDEAD_BEEF, 2);
    tick();
    start_fetch(10'd480);
    cpu_access(1'b1, 14'h300, 32'hCAFE_0001, 32'h0, 2);
    tick();
    cpu_access(1'b0, 14'h300, 32'h0, 32'hCAFE_0001, 2);
    tick();

    // Last visible line still fetches
    start_fetch(10'd479);
    repeat (25) video_cycle(1'b0, 10'd0);
    video_cycle(1'b1, 10'd0);
    video_cycle(1'b1, 10'd1);
    video_cycle(1'b0, 10'd0);
    chk("underrun_final",  32'(bus.underrun),  32'h0);
    chk("addr_q_empty",    32'(addr_q.size()), 32'h0);
    chk("rd_q_empty",      32'(rd_q.size()),   32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port video BRAM between the CPU bus and the VGA scan-out path.
- At the start of each visible line, it prefetches that line's 1-bpp pixel words into an internal line buffer.
- While that line is displayed, it serves pixels from the buffer, and the CPU may use the BRAM freely.
- Sits between the VGA timing generator (newline/ve/x/y) and the SoC data bus.

Parameters:
- ADDR_W, 14, BRAM word-address width.
- DATA_W, 32, BRAM/CPU data width; one word = 32 pixels.
- LINE_WORDS, 20, words per visible line (640/32).
- V_ACTIVE, 480, number of visible lines.
- FB_BASE, 0, word address of line 0.

Ports:
- clk_p  in  1  pixel clock, single clock domain.
- rst  in  1  asynchronous, active-low reset.
- newline  in  1  one-cycle pulse at the start of each line (timing x counter == 0).
- ve  in  1  video enable (visible region).
- x  in  10  visible column; valid while ve=1.
- y  in  10  visible row; >= V_ACTIVE (wrapped) outside the visible field.
- pixel  out  1  monochrome pixel, registered.
- underrun  out  1  sticky error flag.
- cpu_req  in  1  CPU access request, level, held until cpu_ack.
- cpu_we  in  1  1 = write.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid in the cpu_ack cycle.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_rdata  in  DATA_W  BRAM read data, 1-cycle latency after mem_en.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all of pixel, underrun, cpu_ack, mem_en, mem_we, fetch_pending, word counter = 0.
  - mem_addr, mem_wdata, cpu_rdata = 0.
  - Line buffer contents are not reset.
  - Reset mid-fetch or mid-CPU access aborts it; no cpu_ack is issued for an aborted access.
- Fetch trigger:
  - newline=1 with y < V_ACTIVE sets fetch_pending and latches fetch_line=y.
  - No trigger when y >= V_ACTIVE.
- Line address: line_addr = FB_BASE + fetch_line*LINE_WORDS, truncated to ADDR_W. Use constant multiply/shift-add.
- FSM states: IDLE, FETCH, DRAIN, CPU_ISSUE, CPU_ACK.
- IDLE:
  - If fetch_pending: go to FETCH, clear fetch_pending, word counter i=0.
  - Else if cpu_req: go to CPU_ISSUE.
  - If both arrive in the same cycle, fetch wins.
- FETCH: one read per cycle.
  - Drive mem_en=1, mem_we=0, mem_addr = line_addr + i.
  - i increments each cycle. After i = LINE_WORDS-1, go to DRAIN.
  - mem_rdata is written to linebuf[i_delayed] one cycle after each issue.
- DRAIN: capture the last word, then go to IDLE.
  - Total fetch = LINE_WORDS+1 cycles from entering FETCH.
- CPU_ISSUE:
  - Drive mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - Go to CPU_ACK.
- CPU_ACK:
  - cpu_ack=1; cpu_rdata=mem_rdata for reads (holds the previous value on writes).
  - Go to IDLE. If cpu_req is still high, the next grant can occur no sooner than the following IDLE cycle.
- A CPU access in progress is never preempted. A newline arriving during CPU_ISSUE/CPU_ACK is served right after.
- Worst-case CPU latency: LINE_WORDS+4 cycles from cpu_req to cpu_ack.
- Outside FETCH/CPU_ISSUE: mem_en=0, mem_we=0.
- Pixel path:
  - pixel <= ve & linebuf[x[9:5]][31 - x[4:0]], one-cycle latency.
  - Bit 31 is the leftmost pixel.
  - x[9:5] >= LINE_WORDS reads as 0.
- Underrun:
  - Set if ve=1 while state is FETCH/DRAIN or fetch_pending=1.
  - Sticky until reset.
  - With 640x480 timing, the fetch completes about 120 cycles before ve, so underrun must stay 0 in normal operation.

Test Plan:
- Reset release, no requests, BRAM filled with a checkerboard (0xAAAAAAAA) -> mem_en=0 except fetches; pixel alternates 1,0 across visible x; underrun=0 for 2 full frames.
- newline with y=3, BRAM[60..79]=60..79 -> mem_addr sweeps 60..79 on 20 consecutive cycles starting 1 cycle after newline; linebuf word 5 = 65; x=160 shows bit 31 of 65 = 0.
- cpu_req read at addr 0x100 (BRAM=0xDEADBEEF) in idle -> mem_en at T+1, cpu_ack at T+2, cpu_rdata=0xDEADBEEF.
- cpu_req asserted in the same cycle as newline (y=0) -> 20-word fetch first; cpu_ack exactly 24 cycles after req; write of 0x12345678 lands, readback equal.
- Force ve high 5 cycles after newline (short back porch) -> underrun=1 and stays 1; async rst low mid-fetch -> mem_en=0 immediately, underrun=0, no cpu_ack.
- newline with y=500 (vertical blank) -> no fetch, mem_en stays 0, CPU accesses complete in 2 cycles.
